// File: rtl/can_pkg.sv
// can_pkg: shared constants, FSM state encoding and the CRC-15 step
// function for the CAN transmit stuffer.
//   CAN_CRC15_POLY    : CAN CRC-15 generator polynomial
//   CAN_STUFF_LEN_DEF : default run length that triggers a stuff bit
//   CAN_RECESSIVE     : idle bus level
//   can_state_e       : stuffer FSM states
//   crc15_step()      : folds one unstuffed bit into a CRC-15 value
package can_pkg;

   localparam logic [14:0] CAN_CRC15_POLY    = 15'h4599;
   localparam int          CAN_STUFF_LEN_DEF = 5;
   localparam logic        CAN_RECESSIVE     = 1'b1;

   typedef enum logic [0:0] {
      ST_DATA  = 1'b0,
      ST_STUFF = 1'b1
   } can_state_e;

   // One bit of the serial CRC-15: shift left, XOR polynomial on feedback.
   function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic bit_in);
      logic fb;
      fb = bit_in ^ crc[14];
      return {crc[13:0], 1'b0} ^ (fb ? CAN_CRC15_POLY : 15'h0000);
   endfunction

endpackage

// File: rtl/can_crc15_serial.sv
// can_crc15_serial: bit-serial CAN CRC-15 accumulator.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : restart from zero; when en is also high the bit is folded
//              into the cleared value
//   en       : fold bit_in into the CRC this cycle
//   bit_in   : unstuffed frame bit
//   crc      : registered CRC value
import can_pkg::*;

module can_crc15_serial (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        en,
   input  logic        bit_in,
   output logic [14:0] crc
);

   logic [14:0] crc_r;
   logic [14:0] base_s;

   // Starting value for the fold: zero when this bit opens a new frame.
   always_comb begin
      base_s = crc_r;
      if (clr) begin
         base_s = 15'h0000;
      end else begin
         base_s = crc_r;
      end
   end

   // CRC register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         crc_r <= 15'h0000;
      end else if (en) begin
         crc_r <= crc15_step(base_s, bit_in);
      end else if (clr) begin
         crc_r <= 15'h0000;
      end else begin
         crc_r <= crc_r;
      end
   end

   assign crc = crc_r;

endmodule

// File: rtl/can_tx_stuffer.sv
// can_tx_stuffer: bit-serial CAN transmit stage. Takes one unstuffed bit per
// bit_tick over valid/ready, drives the bus level and inserts a complementary
// stuff bit after STUFF_LEN identical bits in stuffed fields.
// Build option: define CAN_TX_CRC_EN to instantiate the CRC-15 accumulator;
// otherwise crc_out is tied to zero and in_crc_en is ignored.
//   clk, rst       : clock, asynchronous active-high reset
//   bit_tick       : bit-boundary strobe
//   in_bit/in_valid/in_stuff_en/in_crc_en/in_sof : frame bit and its attributes
//   in_ready       : bit accepted this cycle (combinational)
//   tx_out         : registered bus level, 1 = recessive
//   stuff_inserted : registered one-cycle pulse when tx_out carries a stuff bit
//   crc_out        : running CRC-15 of accepted in_crc_en bits
import can_pkg::*;

module can_tx_stuffer #(
   parameter int STUFF_LEN = CAN_STUFF_LEN_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bit_tick,
   input  logic        in_bit,
   input  logic        in_valid,
   input  logic        in_stuff_en,
   input  logic        in_crc_en,
   input  logic        in_sof,
   output logic        in_ready,
   output logic        tx_out,
   output logic        stuff_inserted,
   output logic [14:0] crc_out
);

   localparam logic [0:0] S_DATA      = 1'(ST_DATA);
   localparam logic [0:0] S_STUFF     = 1'(ST_STUFF);
   localparam logic [3:0] STUFF_LEN_C = 4'(STUFF_LEN);

   logic [0:0] state_r;
   logic [0:0] state_s;
   logic       tx_out_r;
   logic       tx_s;
   logic       stuff_ins_r;
   logic       ins_s;
   logic [3:0] run_cnt_r;
   logic [3:0] run_s;
   logic [3:0] run_inc_s;
   logic       last_bit_r;
   logic       last_s;

   assign in_ready = bit_tick & (state_r != S_STUFF);

   // Run counter increment, saturating at the stuff length.
   always_comb begin
      run_inc_s = run_cnt_r;
      if (run_cnt_r >= STUFF_LEN_C) begin
         run_inc_s = STUFF_LEN_C;
      end else begin
         run_inc_s = run_cnt_r + 4'd1;
      end
   end

   // Next-state logic: everything advances only on bit_tick.
   always_comb begin
      state_s = state_r;
      tx_s    = tx_out_r;
      ins_s   = 1'b0;
      run_s   = run_cnt_r;
      last_s  = last_bit_r;
      if (bit_tick) begin
         case (state_r)
            S_STUFF: begin
               // The stuff bit opens the next run; the offered input waits.
               tx_s    = ~last_bit_r;
               last_s  = ~last_bit_r;
               run_s   = 4'd1;
               ins_s   = 1'b1;
               state_s = S_DATA;
            end
            S_DATA: begin
               if (in_valid) begin
                  tx_s   = in_bit;
                  last_s = in_bit;
                  if (in_sof) begin
                     run_s = 4'd1;
                  end else if (in_stuff_en) begin
                     run_s = (in_bit == last_bit_r) ? run_inc_s : 4'd1;
                  end else begin
                     run_s = 4'd0;
                  end
                  if (in_stuff_en && (run_s == STUFF_LEN_C)) begin
                     state_s = S_STUFF;
                  end else begin
                     state_s = S_DATA;
                  end
               end else begin
                  tx_s  = CAN_RECESSIVE;
                  run_s = 4'd0;
               end
            end
            default: begin
               tx_s    = CAN_RECESSIVE;
               run_s   = 4'd0;
               state_s = S_DATA;
            end
         endcase
      end else begin
         state_s = state_r;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= S_DATA;
         tx_out_r    <= CAN_RECESSIVE;
         stuff_ins_r <= 1'b0;
         run_cnt_r   <= 4'd0;
         last_bit_r  <= 1'b1;
      end else begin
         state_r     <= state_s;
         tx_out_r    <= tx_s;
         stuff_ins_r <= ins_s;
         run_cnt_r   <= run_s;
         last_bit_r  <= last_s;
      end
   end

   assign tx_out         = tx_out_r;
   assign stuff_inserted = stuff_ins_r;

`ifdef CAN_TX_CRC_EN
   logic xfer_s;
   assign xfer_s = in_valid & in_ready;

   can_crc15_serial u_crc (
      .clk    (clk),
      .rst    (rst),
      .clr    (xfer_s & in_sof),
      .en     (xfer_s & in_crc_en),
      .bit_in (in_bit),
      .crc    (crc_out)
   );
`else
   logic unused_crc_en_s;
   assign unused_crc_en_s = in_crc_en;
   assign crc_out         = 15'h0000;
`endif

endmodule

// File: tb/tb_can_tx_stuffer.sv
// tb_can_tx_stuffer: directed self-checking bench for can_tx_stuffer.
// Each bit is offered for one tick cycle followed by one non-tick cycle, so
// both the tick behaviour and the hold between ticks are observed.
module tb_can_tx_stuffer;

`ifdef CAN_TX_CRC_EN
   localparam bit CRC_ON = 1'b1;
`else
   localparam bit CRC_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        bit_tick = 1'b0;
   logic        in_bit = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_stuff_en = 1'b0;
   logic        in_crc_en = 1'b0;
   logic        in_sof = 1'b0;
   logic        in_ready;
   logic        tx_out;
   logic        stuff_inserted;
   logic [14:0] crc_out;

   int n_cmp = 0;
   int n_err = 0;

   can_tx_stuffer #(.STUFF_LEN(5)) dut (
      .clk            (clk),
      .rst            (rst),
      .bit_tick       (bit_tick),
      .in_bit         (in_bit),
      .in_valid       (in_valid),
      .in_stuff_en    (in_stuff_en),
      .in_crc_en      (in_crc_en),
      .in_sof         (in_sof),
      .in_ready       (in_ready),
      .tx_out         (tx_out),
      .stuff_inserted (stuff_inserted),
      .crc_out        (crc_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Offer one bit on a tick cycle, then one quiet cycle with the same inputs.
   task automatic step(input string tag, input logic b, input logic v, input logic se,
                       input logic ce, input logic sof,
                       input logic exp_rdy, input logic exp_tx, input logic exp_ins);
      @(negedge clk);
      in_bit = b; in_valid = v; in_stuff_en = se; in_crc_en = ce; in_sof = sof;
      bit_tick = 1'b1;
      #1 chk({tag, ".ready"}, {15'd0, in_ready}, {15'd0, exp_rdy});
      @(posedge clk);
      #1;
      chk({tag, ".tx"}, {15'd0, tx_out}, {15'd0, exp_tx});
      chk({tag, ".ins"}, {15'd0, stuff_inserted}, {15'd0, exp_ins});
      @(negedge clk);
      bit_tick = 1'b0;
      #1 chk({tag, ".ready_off"}, {15'd0, in_ready}, 16'd0);
      @(posedge clk);
      #1;
      chk({tag, ".tx_hold"}, {15'd0, tx_out}, {15'd0, exp_tx});
      chk({tag, ".ins_off"}, {15'd0, stuff_inserted}, 16'd0);
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst.tx", {15'd0, tx_out}, 16'd1);
      chk("rst.ins", {15'd0, stuff_inserted}, 16'd0);
      chk("rst.crc", {1'b0, crc_out}, 16'd0);
      @(negedge clk);
      rst = 1'b0;

      // Idle ticks
      step("idle0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      step("idle1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("idle.crc", {1'b0, crc_out}, 16'd0);

      // SOF+0000, stuff 1, then 1111, stuff 0
      step("s0", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      step("s1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step("s2", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step("s3", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step("s4", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step("stuff1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      step("s5", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      step("s6", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      step("s7", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      step("s8", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      step("stuff0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Eight 1s in an unstuffed field: no stuff bits
      for (int i = 0; i < 8; i++) begin
         step($sformatf("ns%0d", i), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      end

      // Trailing run of five 0s, delimiter unstuffed: stuff goes out first
      step("c_sof", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step($sformatf("c%0d", i), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      step("c_stuff", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      step("c_delim", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

      // CRC: SOF 1 then 0, then a second SOF restarts from zero
      step("crc_a", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("crc_a.val", {1'b0, crc_out}, CRC_ON ? 16'h4599 : 16'h0000);
      step("crc_b", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("crc_b.val", {1'b0, crc_out}, CRC_ON ? 16'h4EAB : 16'h0000);
      step("crc_c", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("crc_c.val", {1'b0, crc_out}, CRC_ON ? 16'h4599 : 16'h0000);

      // Reset while a stuff bit is pending
      step("r0", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step($sformatf("r%0d", i + 1), 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      @(negedge clk);
      in_valid = 1'b0; in_stuff_en = 1'b0; in_crc_en = 1'b0; in_sof = 1'b0;
      rst = 1'b1;
      #1;
      chk("rstp.tx", {15'd0, tx_out}, 16'd1);
      chk("rstp.ins", {15'd0, stuff_inserted}, 16'd0);
      chk("rstp.crc", {1'b0, crc_out}, 16'd0);
      @(negedge clk);
      rst = 1'b0;
      step("rstp.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("rstp.crc2", {1'b0, crc_out}, 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
